// File: rtl/udivider.sv
// udivider: sequential unsigned restoring divider, one quotient bit
// per clock. Ports: clk, rst (async high), start, A, B in; Q, R,
// valid_out, busy_out, div_by_zero out. Q/R/div_by_zero registered.
module udivider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             valid_out,
  output logic             busy_out,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE,
    DIV
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] p;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   p_sh;
  logic [WIDTH:0]   diff;
  logic             qbit;
  logic [WIDTH-1:0] p_nx;
  logic [WIDTH-1:0] dvd_nx;
  logic             last;

  // The partial remainder always stays below the divisor, so the
  // shifted value is below 2*B and the top bit of the difference
  // is a reliable borrow flag. With B=0 no borrow ever occurs.
  assign p_sh   = {p, dvd[WIDTH-1]};
  assign diff   = p_sh - {1'b0, dsr};
  assign qbit   = ~diff[WIDTH];
  assign p_nx   = qbit ? diff[WIDTH-1:0]
                       : p_sh[WIDTH-1:0];
  assign dvd_nx = (dvd << 1)
                | {{(WIDTH-1){1'b0}}, qbit};
  assign last   = (state == DIV)
               && (cnt == CW'(1));

  assign busy_out = (state == DIV);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = DIV;
      DIV:  if (last)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      dvd         <= '0;
      dsr         <= '0;
      p           <= '0;
      cnt         <= '0;
      Q           <= '0;
      R           <= '0;
      valid_out   <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state     <= state_nx;
      valid_out <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            dvd <= A;
            dsr <= B;
            p   <= '0;
            cnt <= CW'(WIDTH);
          end
        end
        DIV: begin
          dvd <= dvd_nx;
          p   <= p_nx;
          cnt <= cnt - CW'(1);
          if (last) begin
            Q           <= dvd_nx;
            R           <= p_nx;
            div_by_zero <= (dsr == '0);
            valid_out   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_udivider.sv
// tb_udivider: directed checks for udivider (WIDTH=4).
// Latency, handshake, divide-by-zero, held start, reset, sweep.
module tb_udivider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         valid_out;
  logic         busy_out;
  logic         dz;

  int n_tot = 0;
  int n_pass = 0;

  udivider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .A           (a),
    .B           (b),
    .Q           (q),
    .R           (r),
    .valid_out   (valid_out),
    .busy_out    (busy_out),
    .div_by_zero (dz)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tot++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic go(
    input logic [W-1:0] av,
    input logic [W-1:0] bv
  );
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Call right after the accept edge (+1).
  task automatic wait_valid(
    output int lat,
    output int bc
  );
    lat = 0;
    bc = 0;
    while (!valid_out && lat < 20) begin
      if (busy_out) bc++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run(
    input string        tag,
    input logic [W-1:0] av,
    input logic [W-1:0] bv,
    input logic [W-1:0] eq,
    input logic [W-1:0] er,
    input logic         edz
  );
    int lat, bc;
    go(av, bv);
    wait_valid(lat, bc);
    chk({tag, ".lat"}, lat, 4);
    chk({tag, ".busy"}, bc, 4);
    chk({tag, ".q"}, q, eq);
    chk({tag, ".r"}, r, er);
    chk({tag, ".dz"}, dz, edz);
    chk({tag, ".busy_at_v"}, busy_out, 0);
    @(posedge clk);
    #1;
    chk({tag, ".v_pulse"}, valid_out, 0);
  endtask

  initial begin
    int lat, bc, nv, lastv;
    rst = 1'b1;
    start = 1'b0;
    a = 'x;
    b = 'x;
    #1;
    chk("rst.q", q, 0);
    chk("rst.r", r, 0);
    chk("rst.v", valid_out, 0);
    chk("rst.busy", busy_out, 0);
    chk("rst.dz", dz, 0);
    #11;
    rst = 1'b0;

    run("9/2", 4'd9, 4'd2, 4'd4, 4'd1, 1'b0);
    run("15/1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
    run("3/5", 4'd3, 4'd5, 4'd0, 4'd3, 1'b0);
    run("0/7", 4'd0, 4'd7, 4'd0, 4'd0, 1'b0);
    run("7/0", 4'd7, 4'd0, 4'd15, 4'd7, 1'b1);
    run("8/3", 4'd8, 4'd3, 4'd2, 4'd2, 1'b0);

    // start held 3 cycles, operands change mid-op
    @(negedge clk);
    a = 4'd4;
    b = 4'd2;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 4'd6;
    b = 4'd4;
    @(posedge clk);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("hold.busy", busy_out, 1);
    lat = 2;
    while (!valid_out && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("hold.lat", lat, 4);
    chk("hold.q", q, 2);
    chk("hold.r", r, 0);
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (valid_out || busy_out) nv++;
    end
    chk("hold.extra", nv, 0);

    // start held 12 cycles: back-to-back results
    @(negedge clk);
    a = 4'd13;
    b = 4'd4;
    start = 1'b1;
    nv = 0;
    lastv = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (i == 11) start = 1'b0;
      if (i == 5) chk("b2b.busy5", busy_out, 1);
      if (valid_out) begin
        nv++;
        chk("b2b.q", q, 3);
        chk("b2b.r", r, 1);
        chk("b2b.at", i, 4 + 5 * (nv - 1));
        if (lastv >= 0)
          chk("b2b.gap", i - lastv, 5);
        lastv = i;
      end
    end
    chk("b2b.count", nv, 3);

    // async reset mid-op
    go(4'd14, 4'd3);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mrst.q", q, 0);
    chk("mrst.r", r, 0);
    chk("mrst.busy", busy_out, 0);
    chk("mrst.v", valid_out, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    nv = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (valid_out || busy_out) nv++;
    end
    chk("mrst.noval", nv, 0);
    run("14/3", 4'd14, 4'd3, 4'd4, 4'd2, 1'b0);

    // exhaustive invariant sweep
    nv = 0;
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        go(W'(ai), W'(bi));
        wait_valid(lat, bc);
        if (lat != 4) nv++;
        else if (bi == 0) begin
          if (q != 4'd15 || int'(r) != ai || !dz)
            nv++;
        end else begin
          if (int'(q) * bi + int'(r) != ai
              || int'(r) >= bi || dz)
            nv++;
        end
      end
    end
    chk("sweep.bad", nv, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
